// File: rtl/tri_bus_arbiter_pkg.sv
// tri_arb_pkg -- shared types and constants for the tri-state bus arbiter.
//   arb_state_e  : FSM state encoding (IDLE, GRANT, TURN)
//   owner_idx_t  : widest requester index (up to 8 requesters)
//   range limits : legal bounds for NREQ, TA_CYCLES and MAX_HOLD
//   hold_cnt_w() : counter width able to hold the value MAX_HOLD
//   next_ptr()   : round-robin pointer advance with wrap
package tri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int OWNER_W_MAX  = 3;
  typedef logic [OWNER_W_MAX-1:0] owner_idx_t;

  localparam int NREQ_MIN     = 2;
  localparam int NREQ_MAX     = 8;
  localparam int TA_MIN       = 0;
  localparam int TA_MAX       = 3;
  localparam int MAX_HOLD_MIN = 1;

  function automatic int hold_cnt_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // Advance the round-robin pointer past the released owner, wrapping to 0.
  function automatic owner_idx_t next_ptr(input owner_idx_t cur, input int nreq);
    if (int'(cur) >= nreq - 1)
      return '0;
    else
      return cur + 1'b1;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// tri_bus_arbiter_if -- handshake bundle between requesters and the arbiter.
//   req      requester -> arbiter   level request, one bit per requester
//   done     requester -> arbiter   one-cycle release strobe from the owner
//   gnt      arbiter -> requester   one-hot drive enable
//   owner    arbiter -> requester   index of current/last owner
//   busy     arbiter -> requester   arbiter in GRANT or TURN
//   forced   arbiter -> requester   pulse when the hold limit ended a tenure
//   bus_in   net -> arbiter         sampled shared net (ARB_CONTENTION_CHECK_EN)
//   cont_err arbiter -> requester   sticky contention flag (ARB_CONTENTION_CHECK_EN)
// Modports: master = requester side, slave = arbiter side.
interface tri_bus_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            forced;
`ifdef ARB_CONTENTION_CHECK_EN
  logic [WIDTH-1:0] bus_in;
  logic             cont_err;
`endif

  modport master (
    output req, output done,
    input  gnt, input owner, input busy, input forced
`ifdef ARB_CONTENTION_CHECK_EN
    , output bus_in, input cont_err
`endif
  );

  modport slave (
    input  req, input done,
    output gnt, output owner, output busy, output forced
`ifdef ARB_CONTENTION_CHECK_EN
    , input bus_in, output cont_err
`endif
  );

endinterface

// File: rtl/tri_bus_arbiter_pick.sv
// rr_priority_pick -- combinational round-robin winner selection.
//   req    in   NREQ  request vector
//   ptr    in   IW    highest-priority index
//   onehot out  NREQ  one-hot winner
//   idx    out  IW    winner index
//   valid  out  1     any request present
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // First pass takes the lowest set request at or above ptr; the second
  // pass only runs when nothing was found there, which gives the wrap.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!valid && req[j] && (IW'(j) >= ptr)) begin
        valid     = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter -- round-robin arbiter for the output enables of a shared
// tri-state net. Grants are one-hot and registered, separated by TA_CYCLES
// idle turnaround cycles, and each tenure is capped at MAX_HOLD cycles.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    tri_bus_arbiter_if.slave (req/done in; gnt/owner/busy/forced out;
//          bus_in in / cont_err out when ARB_CONTENTION_CHECK_EN is defined)
// Optional feature macro: ARB_CONTENTION_CHECK_EN (X/Z detection on bus_in).
module tri_bus_arbiter
  import tri_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_HOLD  = 16,
  parameter int TA_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  tri_bus_arbiter_if.slave bus
);

  localparam int IW          = $clog2(NREQ);
  localparam int TA_EFF      = (TA_CYCLES > TA_MAX) ? TA_MAX :
                               (TA_CYCLES < TA_MIN) ? TA_MIN : TA_CYCLES;
  localparam int MAX_HOLD_EFF = (MAX_HOLD < MAX_HOLD_MIN) ? MAX_HOLD_MIN : MAX_HOLD;
  localparam int HW          = hold_cnt_w(MAX_HOLD_EFF);

  arb_state_e      state, stateNext;
  logic [NREQ-1:0] gntReg, gntNext;
  logic [IW-1:0]   ownerIdx, ownerNext;
  logic [IW-1:0]   ptr, ptrNext, ptrInc, pickPtr;
  logic [HW-1:0]   holdCnt, holdNext;
  logic [1:0]      taCnt, taNext;
  logic            forcedReg, forcedNext;

  logic [NREQ-1:0] pickOneHot;
  logic [IW-1:0]   pickIdx;
  logic            pickValid;

  logic ownerDone, ownerReq, limitHit, releaseNow, taLast;

  // gnt is one-hot, so masking with it selects the owner's own bits and
  // every non-owner done/req is ignored for free.
  assign ownerDone  = |(bus.done & gntReg);
  assign ownerReq   = |(bus.req & gntReg);
  assign limitHit   = (holdCnt == HW'(MAX_HOLD_EFF));
  assign releaseNow = ownerDone || !ownerReq || limitHit;
  assign taLast     = (taCnt == 2'(TA_EFF - 1));
  assign ptrInc     = IW'(next_ptr(owner_idx_t'(ownerIdx), NREQ));

  // With zero turnaround the releasing GRANT cycle re-arbitrates, so it must
  // already see the advanced pointer.
  assign pickPtr = (state == GRANT) ? ptrInc : ptr;

  rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (pickPtr),
    .onehot (pickOneHot),
    .idx    (pickIdx),
    .valid  (pickValid)
  );

  // Next-state and next-output logic for the IDLE/GRANT/TURN sequence.
  always_comb begin
    stateNext  = state;
    gntNext    = gntReg;
    ownerNext  = ownerIdx;
    ptrNext    = ptr;
    holdNext   = holdCnt;
    taNext     = taCnt;
    forcedNext = 1'b0;
    case (state)
      IDLE: begin
        if (pickValid) begin
          stateNext = GRANT;
          gntNext   = pickOneHot;
          ownerNext = pickIdx;
          holdNext  = HW'(1);
        end
      end
      GRANT: begin
        if (releaseNow) begin
          gntNext    = '0;
          ptrNext    = ptrInc;
          holdNext   = '0;
          forcedNext = limitHit && !ownerDone && ownerReq;
          if (TA_EFF == 0) begin
            if (pickValid) begin
              stateNext = GRANT;
              gntNext   = pickOneHot;
              ownerNext = pickIdx;
              holdNext  = HW'(1);
            end else begin
              stateNext = IDLE;
            end
          end else begin
            stateNext = TURN;
            taNext    = '0;
          end
        end else begin
          holdNext = holdCnt + HW'(1);
        end
      end
      TURN: begin
        if (taLast) begin
          if (pickValid) begin
            stateNext = GRANT;
            gntNext   = pickOneHot;
            ownerNext = pickIdx;
            holdNext  = HW'(1);
          end else begin
            stateNext = IDLE;
          end
        end else begin
          taNext = taCnt + 2'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        gntNext   = '0;
      end
    endcase
  end

  // State and output registers; reset clears gnt immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gntReg    <= '0;
      ownerIdx  <= '0;
      ptr       <= '0;
      holdCnt   <= '0;
      taCnt     <= '0;
      forcedReg <= 1'b0;
    end else begin
      state     <= stateNext;
      gntReg    <= gntNext;
      ownerIdx  <= ownerNext;
      ptr       <= ptrNext;
      holdCnt   <= holdNext;
      taCnt     <= taNext;
      forcedReg <= forcedNext;
    end
  end

  assign bus.gnt    = gntReg;
  assign bus.owner  = ownerIdx;
  assign bus.busy   = (state != IDLE);
  assign bus.forced = forcedReg;

`ifdef ARB_CONTENTION_CHECK_EN
  logic contErr;

  // The first grant cycle is skipped because the new driver is still
  // turning on; after that any X/Z bit on the net means two drivers fight
  // or nobody drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      contErr <= 1'b0;
    else if ((state == GRANT) && (holdCnt > HW'(1)) && ((^bus.bus_in) === 1'bx))
      contErr <= 1'b1;
  end

  assign bus.cont_err = contErr;
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter -- directed self-checking bench for tri_bus_arbiter
// (NREQ=4, WIDTH=8, MAX_HOLD=16, TA_CYCLES=1). Contention scenario is built
// only when ARB_CONTENTION_CHECK_EN is defined.
module tb_tri_bus_arbiter;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  tri_bus_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  tri_bus_arbiter #(
    .NREQ(4), .WIDTH(8), .MAX_HOLD(16), .TA_CYCLES(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global invariants sampled mid-cycle: gnt one-hot or zero, zero when idle.
  always @(negedge clk) begin
    if (rst_n) begin
      compared++;
      if (!$onehot0(bus.gnt) || (!bus.busy && bus.gnt !== 4'b0000)) begin
        mismatched++;
        $display("[TB] FAIL gnt_invariant: gnt=%b busy=%b required onehot0 and zero when idle",
                 bus.gnt, bus.busy);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic stepEdge;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    doReset;
    compared++;
    if (bus.gnt !== 4'b0000 || bus.owner !== 2'd0 || bus.busy !== 1'b0 || bus.forced !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: gnt=%b owner=%0d busy=%b forced=%b required 0000/0/0/0",
               bus.gnt, bus.owner, bus.busy, bus.forced);
    end
  endtask

  task automatic test_single_grant;
    doReset;
    applyStimulus(4'b0100, 4'b0000);
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_grant: gnt=%b owner=%0d busy=%b required 0100/2/1",
               bus.gnt, bus.owner, bus.busy);
    end
    applyStimulus(4'b0000, 4'b0000);
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.forced !== 1'b0 || bus.owner !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL single_turn: gnt=%b busy=%b forced=%b owner=%0d required 0000/1/0/2",
               bus.gnt, bus.busy, bus.forced, bus.owner);
    end
    stepEdge;
    compared++;
    if (bus.busy !== 1'b0 || bus.owner !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL single_idle: busy=%b owner=%0d required 0/2", bus.busy, bus.owner);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] expGnt;
    doReset;
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      expGnt = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        stepEdge;
        compared++;
        if (bus.gnt !== expGnt) begin
          mismatched++;
          $display("[TB] FAIL rr_grant k=%0d c=%0d: gnt=%b required %b", k, c, bus.gnt, expGnt);
        end
      end
      compared++;
      if (bus.owner !== 2'(k % 4)) begin
        mismatched++;
        $display("[TB] FAIL rr_owner k=%0d: owner=%0d required %0d", k, bus.owner, k % 4);
      end
      applyStimulus(4'b1111, expGnt);
      stepEdge;
      applyStimulus(4'b1111, 4'b0000);
      compared++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.forced !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rr_turn k=%0d: gnt=%b busy=%b forced=%b required 0000/1/0",
                 k, bus.gnt, bus.busy, bus.forced);
      end
    end
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) stepEdge;
  endtask

  task automatic test_hold_limit;
    doReset;
    applyStimulus(4'b0110, 4'b0000);
    for (int c = 1; c <= 16; c++) begin
      stepEdge;
      compared++;
      if (bus.gnt !== 4'b0010 || bus.forced !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold_tenure c=%0d: gnt=%b forced=%b required 0010/0", c, bus.gnt, bus.forced);
      end
    end
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0000 || bus.forced !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_release: gnt=%b forced=%b required 0000/1", bus.gnt, bus.forced);
    end
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0100 || bus.forced !== 1'b0 || bus.owner !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL hold_next: gnt=%b forced=%b owner=%0d required 0100/0/2",
               bus.gnt, bus.forced, bus.owner);
    end
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) stepEdge;
  endtask

  task automatic test_drop_wrap;
    doReset;
    applyStimulus(4'b0100, 4'b0000);
    stepEdge;
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) stepEdge;
    applyStimulus(4'b1000, 4'b0000);
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL wrap_owner3: gnt=%b owner=%0d required 1000/3", bus.gnt, bus.owner);
    end
    applyStimulus(4'b1101, 4'b0000);
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL wrap_hold: gnt=%b required 1000", bus.gnt);
    end
    applyStimulus(4'b0101, 4'b0000);
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.forced !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wrap_turn: gnt=%b busy=%b forced=%b required 0000/1/0",
               bus.gnt, bus.busy, bus.forced);
    end
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_regrant: gnt=%b owner=%0d required 0001/0", bus.gnt, bus.owner);
    end
    applyStimulus(4'b0000, 4'b0000);
    repeat (3) stepEdge;
  endtask

  task automatic test_reset_mid_tenure;
    doReset;
    applyStimulus(4'b0010, 4'b0000);
    stepEdge;
    applyStimulus(4'b0000, 4'b0000);
    stepEdge;
    applyStimulus(4'b0100, 4'b0000);
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL midrst_pre: gnt=%b required 0100", bus.gnt);
    end
    stepEdge;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL midrst_async: gnt=%b busy=%b owner=%0d required 0000/0/0",
               bus.gnt, bus.busy, bus.owner);
    end
    applyStimulus(4'b0110, 4'b0000);
    stepEdge;
    rst_n = 1'b1;
    stepEdge;
    compared++;
    if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL midrst_pointer: gnt=%b owner=%0d required 0010/1", bus.gnt, bus.owner);
    end
    applyStimulus(4'b0000, 4'b0000);
    repeat (3) stepEdge;
  endtask

`ifdef ARB_CONTENTION_CHECK_EN
  task automatic test_contention;
    bus.bus_in = 8'h00;
    doReset;
    applyStimulus(4'b0001, 4'b0000);
    stepEdge;
    bus.bus_in = 8'b0000_x000;
    stepEdge;
    compared++;
    if (bus.cont_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cont_first_cycle: cont_err=%b required 0", bus.cont_err);
    end
    stepEdge;
    compared++;
    if (bus.cont_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cont_set: cont_err=%b required 1", bus.cont_err);
    end
    bus.bus_in = 8'h00;
    applyStimulus(4'b0000, 4'b0000);
    repeat (4) stepEdge;
    compared++;
    if (bus.cont_err !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cont_sticky: cont_err=%b busy=%b required 1/0", bus.cont_err, bus.busy);
    end
    doReset;
    compared++;
    if (bus.cont_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cont_reset: cont_err=%b required 0", bus.cont_err);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
`ifdef ARB_CONTENTION_CHECK_EN
    bus.bus_in = 8'h00;
`endif
    $display("[TB] starting tri_bus_arbiter directed tests");
    test_reset;
    test_single_grant;
    test_round_robin;
    test_hold_limit;
    test_drop_wrap;
    test_reset_mid_tenure;
`ifdef ARB_CONTENTION_CHECK_EN
    test_contention;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
